// File: rtl/vpe_psum_acc.sv
// vpe_psum_acc: groups a run-time number of consecutive PE partial results,
// sums them at full width and saturates each group sum back to DW bits.
// Group sums are queued in a 2-entry in-order buffer on the output side.
//
// Output handshake: o_data_v means the buffer head in o_data is valid. The
// head is consumed on any clk edge where o_data_v && o_ready. o_data holds
// steady until it is consumed, and reads 0 while the buffer is empty. The
// input side has no ready: a beat arrives whenever i_data_v is high. A group
// result that finds the buffer full, with no pop in the same cycle, is
// dropped and sets the sticky o_ovf flag.
module vpe_psum_acc #(
  parameter int DW    = 8,
  parameter int LEN_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             i_clear,
  input  logic [DW-1:0]    i_data,
  input  logic             i_data_v,
  output logic [DW-1:0]    o_data,
  output logic             o_data_v,
  input  logic             o_ready,
  output logic             o_busy,
  output logic             o_ovf
);

  generate
    if (ACC_W < DW + LEN_W) begin : g_width_check
      $error("vpe_psum_acc: ACC_W must be >= DW + LEN_W");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic signed [ACC_W-1:0]  data_sx;
  logic signed [ACC_W-1:0]  sum;
  logic [LEN_W:0]           cnt_inc;
  logic                     push_req;
  logic [DW-1:0]            push_val;

  logic [DW-1:0]            mem_q [2];
  logic                     rd_ptr_q, wr_ptr_q;
  logic [1:0]               occ_q;
  logic                     pop, push_ok;

  assign data_sx = {{(ACC_W - DW){i_data[DW-1]}}, i_data};
  assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  // State register together with the group datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next state: open, extend, complete or abort a group; raise a push on completion
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sum      = '0;
    push_req = 1'b0;
    push_val = '0;
    if (i_clear) begin
      // Abort wins over a same-cycle beat; that beat is simply lost
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (i_data_v) begin
      if (state_q == IDLE) begin
        len_d = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        sum   = data_sx;
        if (len_d == LEN_W'(1)) begin
          push_req = 1'b1;
        end else begin
          acc_d   = sum;
          cnt_d   = LEN_W'(1);
          state_d = ACC;
        end
      end else begin
        sum = acc_q + data_sx;
        if (cnt_inc == {1'b0, len_q}) begin
          push_req = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          acc_d = sum;
          cnt_d = cnt_inc[LEN_W-1:0];
        end
      end
    end
    if (push_req) begin
      if (sum > SAT_MAX)      push_val = SAT_MAX[DW-1:0];
      else if (sum < SAT_MIN) push_val = SAT_MIN[DW-1:0];
      else                    push_val = sum[DW-1:0];
    end
  end

  // Outputs: busy mirrors the open-group state, data shows the buffer head or 0
  always_comb begin
    o_busy   = (state_q == ACC);
    o_data_v = (occ_q != 2'd0);
    o_data   = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  end

  assign pop     = o_data_v && o_ready;
  assign push_ok = push_req && ((occ_q != 2'd2) || pop);

  // Output buffer: in-order 2-entry FIFO; a full buffer still accepts a push when it pops
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      o_ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_val;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push_ok && !pop)      occ_q <= occ_q + 2'd1;
      else if (!push_ok && pop) occ_q <= occ_q - 2'd1;
      if (push_req && !push_ok) o_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vpe_psum_acc.sv
// tb_vpe_psum_acc: directed plus random stimulus for vpe_psum_acc, compared
// every cycle against a queue-based reference model of the group/buffer rules.
module tb_vpe_psum_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_len;
  logic       i_clear;
  logic [7:0] i_data;
  logic       i_data_v;
  logic [7:0] o_data;
  logic       o_data_v;
  logic       o_ready;
  logic       o_busy;
  logic       o_ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         grp[$];
  int         glen = 1;
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;

  vpe_psum_acc #(.DW(8), .LEN_W(8), .ACC_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_len  (cfg_len),
    .i_clear  (i_clear),
    .i_data   (i_data),
    .i_data_v (i_data_v),
    .o_data   (o_data),
    .o_data_v (o_data_v),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_ovf    (o_ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model one clock edge from the spec rules: groups as lists of beats, buffer as a bounded queue
  task automatic model_edge(input bit r, input bit v, input logic [7:0] d,
                            input logic [7:0] len, input bit clr, input bit rdy);
    bit         do_push = 1'b0;
    logic [7:0] pval = 8'h00;
    int         total;
    if (r) begin
      grp.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      return;
    end
    if (clr) begin
      grp.delete();
    end else if (v) begin
      if (grp.size() == 0) glen = (len == 8'd0) ? 1 : int'(len);
      grp.push_back(int'($signed(d)));
      if (grp.size() == glen) begin
        total = 0;
        foreach (grp[i]) total += grp[i];
        if (total > 127)       pval = 8'h7F;
        else if (total < -128) pval = 8'h80;
        else                   pval = 8'(total);
        do_push = 1'b1;
        grp.delete();
      end
    end
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (do_push) begin
      if (exp_q.size() < 2) exp_q.push_back(pval);
      else                  m_ovf = 1'b1;
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, sample after the edge
  task automatic step(input bit r, input bit v, input logic [7:0] d,
                      input logic [7:0] len, input bit clr, input bit rdy);
    rst      = r;
    i_data_v = v;
    i_data   = d;
    cfg_len  = len;
    i_clear  = clr;
    o_ready  = rdy;
    model_edge(r, v, d, len, clr, rdy);
    @(posedge clk);
    #1;
    check("o_data_v", {31'd0, o_data_v}, {31'd0, exp_q.size() > 0});
    check("o_data", {24'd0, o_data}, {24'd0, (exp_q.size() > 0) ? exp_q[0] : 8'h00});
    check("o_busy", {31'd0, o_busy}, {31'd0, grp.size() > 0});
    check("o_ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] len, input bit rdy);
    step(1'b0, 1'b1, d, len, 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'd1, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b1; cfg_len = 8'd0; i_clear = 1'b0; i_data = 8'h00; i_data_v = 1'b0; o_ready = 1'b0;

    // Reset with junk on the inputs
    step(1'b1, 1'b1, 8'h55, 8'd3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    check("reset_data", {24'd0, o_data}, 32'd0);

    // Four-beat group
    beat(8'd10, 8'd4, 1'b1);
    check("busy_g4_1", {31'd0, o_busy}, 32'd1);
    beat(8'd20, 8'd4, 1'b1);
    beat(8'd30, 8'd4, 1'b1);
    beat(8'd40, 8'd4, 1'b1);
    check("sum_100", {24'd0, o_data}, 32'h64);
    check("sum_100_v", {31'd0, o_data_v}, 32'd1);
    idle(1, 1'b1);
    check("sum_100_vfall", {31'd0, o_data_v}, 32'd0);

    // Saturation
    for (int i = 0; i < 3; i++) beat(8'd100, 8'd3, 1'b1);
    check("sat_pos", {24'd0, o_data}, 32'h7F);
    for (int i = 0; i < 3; i++) beat(8'(-100), 8'd3, 1'b1);
    check("sat_neg", {24'd0, o_data}, 32'h80);
    beat(8'd127, 8'd2, 1'b1);
    beat(8'h80, 8'd2, 1'b1);
    check("sum_m1", {24'd0, o_data}, 32'hFF);

    // Length 0 behaves as length 1, back to back
    beat(8'd5, 8'd0, 1'b1);
    check("len0_a", {24'd0, o_data}, 32'h05);
    beat(8'(-7), 8'd0, 1'b1);
    check("len0_b", {24'd0, o_data}, 32'hF9);
    beat(8'd9, 8'd0, 1'b1);
    check("len0_c", {24'd0, o_data}, 32'h09);
    idle(1, 1'b1);

    // Backpressure and overflow
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd2, 8'd1, 1'b0);
    beat(8'd3, 8'd1, 1'b0);
    check("ovf_set", {31'd0, o_ovf}, 32'd1);
    idle(1, 1'b1);
    check("bp_second", {24'd0, o_data}, 32'h02);
    idle(2, 1'b1);
    check("ovf_sticky", {31'd0, o_ovf}, 32'd1);

    // Full buffer with simultaneous pop and push
    step(1'b1, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0);
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd2, 8'd1, 1'b0);
    beat(8'd7, 8'd1, 1'b1);
    check("fullpop_ovf", {31'd0, o_ovf}, 32'd0);
    idle(3, 1'b1);

    // Abort mid-group, then a fresh group
    beat(8'd10, 8'd4, 1'b1);
    beat(8'd20, 8'd4, 1'b1);
    step(1'b0, 1'b1, 8'd30, 8'd4, 1'b1, 1'b1);
    check("clr_busy", {31'd0, o_busy}, 32'd0);
    for (int i = 0; i < 4; i++) beat(8'd1, 8'd4, 1'b1);
    check("after_clr", {24'd0, o_data}, 32'h04);
    idle(1, 1'b1);

    // Reset mid-group with one buffered entry
    beat(8'd9, 8'd1, 1'b0);
    beat(8'd3, 8'd4, 1'b0);
    beat(8'd4, 8'd4, 1'b0);
    step(1'b1, 1'b1, 8'd5, 8'd4, 1'b0, 1'b0);
    check("rst_mid_v", {31'd0, o_data_v}, 32'd0);
    check("rst_mid_busy", {31'd0, o_busy}, 32'd0);

    // Random traffic including cfg_len changes inside open groups
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           8'($urandom_range(0, 5)), $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
